// File: rtl/crossing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossing_pkg
// Purpose  : Shared state encodings and constants for the crossing request stage.
// Revision : 1.0 - initial release
// ============================================================================
package crossing_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PENDING = 2'b01;
    localparam logic [1:0] ST_SERVING = 2'b10;

    localparam logic [7:0] REQ_COUNT_MAX = 8'd255;

    // walk input is bit WALK_BIT of the controller's lightseq bus
    localparam int WALK_BIT = 4;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PENDING = ST_PENDING,
        SERVING = ST_SERVING
    } state_t;

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : 2-flop synchroniser, counter debounce and one-cycle press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_a;
    logic             sync_b;
    logic             deb;
    logic             deb_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            deb_q  <= deb;
            // any return to the accepted level restarts the stability count
            if (sync_b == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync_b;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign press = deb & ~deb_q;

endmodule
`default_nettype wire

// File: rtl/crossing_request.sv
`default_nettype none
// ============================================================================
// Module   : crossing_request
// Purpose  : Debounced pedestrian/cyclist request latch driving start and WAIT.
//            Optional accepted-request counter enabled by CROSSING_REQ_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crossing_request
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_btn,
    input  logic       cyc_btn,
    input  logic       walk,
    output logic       start,
    output logic       wait_lamp
`ifdef CROSSING_REQ_COUNT_EN
    ,
    output logic [7:0] req_count
`endif
);

    logic   ped_press;
    logic   cyc_press;
    logic   req;
    state_t state;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_deb (
        .clock (clock),
        .reset (reset),
        .btn   (ped_btn),
        .press (ped_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cyc_deb (
        .clock (clock),
        .reset (reset),
        .btn   (cyc_btn),
        .press (cyc_press)
    );

    assign req = ped_press | cyc_press;

    // presses are only looked at in IDLE: absorbed while pending, locked out while serving
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            start     <= 1'b0;
            wait_lamp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= PENDING;
                        start     <= 1'b1;
                        wait_lamp <= 1'b1;
                    end
                end
                PENDING: begin
                    if (walk) begin
                        state     <= SERVING;
                        start     <= 1'b0;
                        wait_lamp <= 1'b0;
                    end
                end
                SERVING: begin
                    if (!walk) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    start     <= 1'b0;
                    wait_lamp <= 1'b0;
                end
            endcase
        end
    end

`ifdef CROSSING_REQ_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_count <= 8'd0;
        end else if (state == IDLE && req && req_count != REQ_COUNT_MAX) begin
            req_count <= req_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_crossing_request.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossing_request
// Purpose  : Directed self-checking bench for crossing_request (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossing_request;

    logic       clock;
    logic       reset;
    logic       ped_btn;
    logic       cyc_btn;
    logic       walk;
    logic       start;
    logic       wait_lamp;
`ifdef CROSSING_REQ_COUNT_EN
    logic [7:0] req_count;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   t0;
    logic start_prev;
    int   exp_q[$];

    crossing_request #(.DEBOUNCE_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .ped_btn   (ped_btn),
        .cyc_btn   (cyc_btn),
        .walk      (walk),
        .start     (start),
        .wait_lamp (wait_lamp)
`ifdef CROSSING_REQ_COUNT_EN
        ,
        .req_count (req_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one clock; each start rising edge pops the cycle at which it was expected
    task automatic tick();
        int e;
        @(posedge clock);
        #1;
        cycle++;
        if (start === 1'b1 && start_prev !== 1'b1) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL start_rise_unexpected: observed=rise at cycle %0d expected=no rise", cycle);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("start_rise_cycle", cycle, e);
            end
        end
        start_prev = start;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic tick_until(input int target);
        while (cycle < target) tick();
    endtask

    initial begin
        reset      = 1'b0;
        ped_btn    = 1'b0;
        cyc_btn    = 1'b0;
        walk       = 1'b0;
        start_prev = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_start", start, 0);
            check("reset_wait", wait_lamp, 0);
`ifdef CROSSING_REQ_COUNT_EN
            check("reset_count", req_count, 0);
`endif
        end
        reset = 1'b1;
        ticks(2);

        // clean pedestrian press
        t0 = cycle;
        ped_btn = 1'b1;
        exp_q.push_back(t0 + 7);
        ticks(6);
        check("clean_start_early", start, 0);
        tick();
        check("clean_start", start, 1);
        check("clean_wait", wait_lamp, 1);
        ticks(3);
        ped_btn = 1'b0;
        tick_until(t0 + 19);
        check("clean_start_held", start, 1);
        check("clean_wait_held", wait_lamp, 1);
        tick_until(t0 + 20);
        walk = 1'b1;
        tick();
        check("walk_start_drop", start, 0);
        check("walk_wait_drop", wait_lamp, 0);
        tick_until(t0 + 30);
        walk = 1'b0;
        tick();
        check("serve_end_start", start, 0);
`ifdef CROSSING_REQ_COUNT_EN
        check("clean_count", req_count, 1);
`endif
        ticks(4);

        // cyclist bounce then stable high
        cyc_btn = 1'b1; tick();
        cyc_btn = 1'b0; tick();
        cyc_btn = 1'b1; tick();
        cyc_btn = 1'b0; tick();
        t0 = cycle;
        cyc_btn = 1'b1;
        exp_q.push_back(t0 + 7);
        ticks(6);
        check("bounce_start_early", start, 0);
        tick();
        check("bounce_start", start, 1);
        walk = 1'b1; tick();
        walk = 1'b0; ticks(2);
        cyc_btn = 1'b0;
        ticks(8);

        // 3-cycle glitch must never be accepted
        cyc_btn = 1'b1;
        ticks(3);
        cyc_btn = 1'b0;
        ticks(12);
        check("glitch_no_start", start, 0);
        check("glitch_no_wait", wait_lamp, 0);

        // lockout during SERVING
        t0 = cycle;
        ped_btn = 1'b1;
        exp_q.push_back(t0 + 7);
        ticks(7);
        check("lock_pending", start, 1);
        walk = 1'b1;
        tick();
        check("lock_serving", start, 0);
        ped_btn = 1'b0;
        ticks(8);
        ped_btn = 1'b1;
        ticks(10);
        check("lock_press_ignored", start, 0);
        check("lock_wait_off", wait_lamp, 0);
        walk = 1'b0;
        tick();
        ped_btn = 1'b0;
        ticks(8);
        t0 = cycle;
        ped_btn = 1'b1;
        exp_q.push_back(t0 + 7);
        ticks(7);
        check("lock_after_start", start, 1);
        walk = 1'b1; tick();
        walk = 1'b0; tick();
        ped_btn = 1'b0;
        ticks(8);
`ifdef CROSSING_REQ_COUNT_EN
        check("pre_sim_count", req_count, 4);
`endif

        // simultaneous presses form one request
        t0 = cycle;
        ped_btn = 1'b1;
        cyc_btn = 1'b1;
        exp_q.push_back(t0 + 7);
        ticks(7);
        check("sim_start", start, 1);
        ticks(3);
        check("sim_start_held", start, 1);
`ifdef CROSSING_REQ_COUNT_EN
        check("sim_count", req_count, 5);
`endif
        ped_btn = 1'b0;
        cyc_btn = 1'b0;
        ticks(8);
        check("sim_still_pending", wait_lamp, 1);

        // asynchronous reset between edges while PENDING
        #2 reset = 1'b0;
        #1;
        check("areset_start", start, 0);
        check("areset_wait", wait_lamp, 0);
`ifdef CROSSING_REQ_COUNT_EN
        check("areset_count", req_count, 0);
`endif
        start_prev = 1'b0;
        #2 reset = 1'b1;
        ticks(10);
        check("post_reset_start", start, 0);
        check("post_reset_wait", wait_lamp, 0);

        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("FAIL missing_start_rise: observed=%0d outstanding expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
